// File: rtl/orientation_rx_if.sv
// Serial link between the microcontroller and orientation_rx.
// Latency: none; plain wires.
// Backpressure: none; the link is framed by load and paced by the sender's sck.
//
// Signals:
//   sck  - serial clock driven by the microcontroller
//   sdi  - serial data, sampled on sck rising edge
//   load - frame enable, high for the whole frame
//   sdo  - readback bit returned to the microcontroller
//
// Modports:
//   master - microcontroller side
//   slave  - receiver side
interface orientation_rx_if;
  logic sck;
  logic sdi;
  logic load;
  logic sdo;

  modport master (output sck, output sdi, output load, input sdo);
  modport slave  (input sck, input sdi, input load, output sdo);
endinterface

// File: rtl/orientation_rx.sv
// Receives a framed serial cube orientation and commits it atomically to a held bus.
// Latency: load fall at pin -> orient_valid 4 clk later (hold low), else 1 clk after hold is seen low.
// Backpressure: hold defers the commit; serial traffic arriving while deferred is discarded with frame_err.
//
// Ports:
//   clk          - system clock
//   reset        - asynchronous, active-low reset
//   ser          - serial link (sck, sdi, load in; sdo out), slave side
//   hold         - downstream core is mid-stream; commit must wait
//   orientation  - committed frame, square k in bits [8k+7:8k]
//   orient_valid - one-cycle pulse on the cycle orientation updates
//   frame_err    - one-cycle pulse when a frame is rejected
//   busy         - receiver is not idle
//
// Build option: define ORIENT_CODE_CHECK_EN to also reject frames with any square byte above 5.
module orientation_rx #(
  parameter int NBITS = 432
) (
  input  logic             clk,
  input  logic             reset,
  orientation_rx_if.slave  ser,
  input  logic             hold,
  output logic [NBITS-1:0] orientation,
  output logic             orient_valid,
  output logic             frame_err,
  output logic             busy
);

  localparam logic [9:0] NBITS_CNT = 10'(NBITS);
  localparam logic [9:0] CNT_MAX   = 10'd511;

  typedef enum logic [1:0] {IDLE, SHIFT, CHECK, PEND} state_t;

  state_t             state_q,        state_d;
  logic [2:0]         sck_q,          sck_d;
  logic [1:0]         sdi_q,          sdi_d;
  logic [2:0]         load_q,         load_d;
  logic [NBITS-1:0]   shadow_q,       shadow_d;
  logic [9:0]         bitcnt_q,       bitcnt_d;
  logic               pend_ok_q,      pend_ok_d;
  logic [NBITS-1:0]   orientation_q,  orientation_d;
  logic               orient_valid_q, orient_valid_d;
  logic               frame_err_q,    frame_err_d;

  logic sck_rise;
  logic load_rise;
  logic load_fall;
  logic sdi_s;
  logic code_ok;
  logic frame_good;

  // sdi goes through two flops and sck through three, so sdi_s is aligned
  // with the same synchroniser stage that sck_rise is detected on.
  always_comb begin
    sck_d     = {sck_q[1:0], ser.sck};
    sdi_d     = {sdi_q[0], ser.sdi};
    load_d    = {load_q[1:0], ser.load};
    sck_rise  = sck_q[1] & ~sck_q[2];
    load_rise = load_q[1] & ~load_q[2];
    load_fall = ~load_q[1] & load_q[2];
    sdi_s     = sdi_q[1];
  end

  always_comb begin
`ifdef ORIENT_CODE_CHECK_EN
    code_ok = 1'b1;
    for (int k = 0; k < NBITS / 8; k++) begin
      if (shadow_q[8*k +: 8] > 8'd5) code_ok = 1'b0;
    end
`else
    code_ok = 1'b1;
`endif
    frame_good = (bitcnt_q == NBITS_CNT) && code_ok;
  end

  always_comb begin
    state_d        = state_q;
    shadow_d       = shadow_q;
    bitcnt_d       = bitcnt_q;
    pend_ok_d      = pend_ok_q;
    orientation_d  = orientation_q;
    orient_valid_d = 1'b0;
    frame_err_d    = 1'b0;

    // A frame that started while a commit was pending is rejected at its
    // load fall, whether or not the pending commit has happened by then.
    if (load_fall && pend_ok_q) begin
      frame_err_d = 1'b1;
      pend_ok_d   = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (load_rise) begin
          bitcnt_d = '0;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        if (sck_rise) begin
          shadow_d = {shadow_q[NBITS-2:0], sdi_s};
          bitcnt_d = (bitcnt_q == CNT_MAX) ? bitcnt_q : bitcnt_q + 10'd1;
        end
        if (load_fall) state_d = CHECK;
      end
      CHECK: begin
        if (!frame_good) begin
          frame_err_d = 1'b1;
          state_d     = IDLE;
        end else if (!hold) begin
          orientation_d  = shadow_q;
          orient_valid_d = 1'b1;
          state_d        = IDLE;
        end else begin
          state_d = PEND;
        end
      end
      PEND: begin
        if (load_rise) pend_ok_d = 1'b1;
        if (!hold) begin
          orientation_d  = shadow_q;
          orient_valid_d = 1'b1;
          state_d        = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      sck_q          <= '0;
      sdi_q          <= '0;
      load_q         <= '0;
      shadow_q       <= '1;
      bitcnt_q       <= '0;
      pend_ok_q      <= 1'b0;
      orientation_q  <= '1;
      orient_valid_q <= 1'b0;
      frame_err_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      sck_q          <= sck_d;
      sdi_q          <= sdi_d;
      load_q         <= load_d;
      shadow_q       <= shadow_d;
      bitcnt_q       <= bitcnt_d;
      pend_ok_q      <= pend_ok_d;
      orientation_q  <= orientation_d;
      orient_valid_q <= orient_valid_d;
      frame_err_q    <= frame_err_d;
    end
  end

  assign ser.sdo      = load_q[1] & shadow_q[NBITS-1];
  assign orientation  = orientation_q;
  assign orient_valid = orient_valid_q;
  assign frame_err    = frame_err_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_orientation_rx.sv
module tb_orientation_rx;
  localparam int NB = 432;

  logic          clk;
  logic          reset;
  logic          hold;
  logic [NB-1:0] orientation;
  logic          orient_valid;
  logic          frame_err;
  logic          busy;

  orientation_rx_if sif ();

  orientation_rx #(.NBITS(NB)) dut (
    .clk          (clk),
    .reset        (reset),
    .ser          (sif),
    .hold         (hold),
    .orientation  (orientation),
    .orient_valid (orient_valid),
    .frame_err    (frame_err),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_valid = 0;
  int n_err   = 0;
  int sdo_ones = 0;

  always @(negedge clk) begin
    if (orient_valid) n_valid++;
    if (frame_err) n_err++;
  end

  task automatic check(input string tag, input logic [NB-1:0] obs, input logic [NB-1:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NB-1:0] pat(input int off);
    logic [NB-1:0] p;
    p = '0;
    for (int k = 0; k < NB / 8; k++) p[8*k +: 8] = 8'((k + off) % 6);
    return p;
  endfunction

  // Bits go out MSB first so vec lands in shadow unchanged; sdo is sampled
  // just before each sck rise.
  task automatic send_frame(input logic [NB-1:0] vec, input int nbits);
    sif.load = 1'b1;
    repeat (4) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      if (i < NB) sif.sdi = vec[NB-1-i];
      else        sif.sdi = 1'b0;
      repeat (3) @(negedge clk);
      if (sif.sdo) sdo_ones++;
      sif.sck = 1'b1;
      repeat (3) @(negedge clk);
      sif.sck = 1'b0;
    end
    repeat (3) @(negedge clk);
    sif.load = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 99;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (orient_valid && lat == 99) lat = k;
    end
  endtask

  logic [NB-1:0] nom, alt, pb, pc;
  int lat, v0, e0;

  initial begin
    nom = pat(0);
    alt = pat(1);
    pb  = pat(2);
    pc  = nom;
    pc[87:80] = 8'h07;

    reset = 1'b0; hold = 1'b0;
    sif.sck = 1'b0; sif.sdi = 1'b0; sif.load = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_orientation", orientation, '1);
    check("rst_valid", NB'(orient_valid), '0);
    check("rst_err", NB'(frame_err), '0);
    check("rst_busy", NB'(busy), '0);
    check("rst_sdo", NB'(sif.sdo), '0);

    // Nominal frame
    v0 = n_valid; e0 = n_err;
    send_frame(nom, NB);
    wait_valid(lat);
    check("nom_latency", NB'(lat), NB'(4));
    check("nom_orientation", orientation, nom);
    check("nom_sq0", NB'(orientation[7:0]), NB'(8'h00));
    check("nom_sq1", NB'(orientation[15:8]), NB'(8'h01));
    check("nom_valid_cnt", NB'(n_valid - v0), NB'(1));
    check("nom_err_cnt", NB'(n_err - e0), NB'(0));

    // Short and long frames
    v0 = n_valid; e0 = n_err;
    send_frame(alt, NB - 1);
    repeat (20) @(negedge clk);
    check("short_err_cnt", NB'(n_err - e0), NB'(1));
    check("short_valid_cnt", NB'(n_valid - v0), NB'(0));
    check("short_orientation", orientation, nom);
    v0 = n_valid; e0 = n_err;
    send_frame(alt, NB + 1);
    repeat (20) @(negedge clk);
    check("long_err_cnt", NB'(n_err - e0), NB'(1));
    check("long_valid_cnt", NB'(n_valid - v0), NB'(0));
    check("long_orientation", orientation, nom);

    // Deferred commit
    v0 = n_valid; e0 = n_err;
    hold = 1'b1;
    send_frame(alt, NB);
    repeat (100) @(negedge clk);
    check("defer_busy", NB'(busy), NB'(1));
    check("defer_no_valid", NB'(n_valid - v0), NB'(0));
    check("defer_orientation_held", orientation, nom);
    hold = 1'b0;
    @(negedge clk);
    check("defer_valid_1cyc", NB'(orient_valid), NB'(1));
    check("defer_orientation", orientation, alt);
    @(negedge clk);
    check("defer_valid_pulse", NB'(orient_valid), NB'(0));
    check("defer_busy_done", NB'(busy), NB'(0));

    // Second frame during PEND; hold drops while it is still streaming
    hold = 1'b1;
    send_frame(nom, NB);
    repeat (10) @(negedge clk);
    v0 = n_valid; e0 = n_err;
    fork
      send_frame(pb, NB);
      begin
        repeat (1500) @(negedge clk);
        hold = 1'b0;
      end
    join
    repeat (20) @(negedge clk);
    check("pend_valid_cnt", NB'(n_valid - v0), NB'(1));
    check("pend_err_cnt", NB'(n_err - e0), NB'(1));
    check("pend_orientation", orientation, nom);
    check("pend_busy", NB'(busy), NB'(0));

    // Square code 0x07 in square 10
    v0 = n_valid; e0 = n_err;
    send_frame(pc, NB);
    repeat (20) @(negedge clk);
`ifdef ORIENT_CODE_CHECK_EN
    check("code_err_cnt", NB'(n_err - e0), NB'(1));
    check("code_valid_cnt", NB'(n_valid - v0), NB'(0));
    check("code_orientation", orientation, nom);
`else
    check("code_err_cnt", NB'(n_err - e0), NB'(0));
    check("code_valid_cnt", NB'(n_valid - v0), NB'(1));
    check("code_sq10", NB'(orientation[87:80]), NB'(8'h07));
`endif

    // Reset mid-frame after 200 bits
    v0 = n_valid; e0 = n_err;
    sif.load = 1'b1;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 200; i++) begin
      sif.sdi = alt[NB-1-i];
      repeat (3) @(negedge clk);
      sif.sck = 1'b1;
      repeat (3) @(negedge clk);
      sif.sck = 1'b0;
    end
    reset = 1'b0;
    sif.load = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    check("abort_no_pulses", NB'((n_valid - v0) + (n_err - e0)), NB'(0));
    check("abort_orientation", orientation, '1);
    check("abort_busy", NB'(busy), NB'(0));
    v0 = n_valid;
    sdo_ones = 0;
    send_frame(pb, NB);
    repeat (20) @(negedge clk);
    check("clean_sdo_echo", NB'(sdo_ones), NB'(NB));
    check("clean_valid_cnt", NB'(n_valid - v0), NB'(1));
    check("clean_orientation", orientation, pb);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
